// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA256 digest egress path.
// The optional SHA256_HEX_UPPERCASE_EN macro (see sha256_nibble_to_ascii)
// selects 'A'-'F' instead of 'a'-'f' for hex letters.
package sha256_pkg;

  localparam int unsigned DEFAULT_DIGEST_BITS = 256;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEX  = 2'd1,
    ST_TERM = 2'd2
  } ser_state_e;

endpackage

// File: rtl/sha256_nibble_to_ascii.sv
// Combinational 4-bit value to ASCII hex digit.
// SHA256_HEX_UPPERCASE_EN defined: letters 'A'-'F'; undefined: 'a'-'f'.
module sha256_nibble_to_ascii
  import sha256_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

`ifdef SHA256_HEX_UPPERCASE_EN
  localparam logic [7:0] LETTER_BASE = ASCII_UA;
`else
  localparam logic [7:0] LETTER_BASE = ASCII_LA;
`endif

  logic [3:0] letter_ofs;

  assign letter_ofs = nibble - 4'd10;

  // Digits 0-9 map from '0'; values 10-15 map from the letter base.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ascii = ASCII_0 + {4'h0, nibble};
    if (nibble > 4'd9) begin
      ascii = LETTER_BASE + {4'h0, letter_ofs};
    end
  end

endmodule

// File: rtl/sha256_hex_serializer.sv
// Serializes a captured digest as ASCII hex (MSB nibble first) on a
// valid/ready byte stream, optionally followed by a terminator byte.
// Letter case follows SHA256_HEX_UPPERCASE_EN (handled in sha256_nibble_to_ascii).
module sha256_hex_serializer
  import sha256_pkg::*;
#(
  parameter int unsigned DIGEST_BITS = DEFAULT_DIGEST_BITS,
  parameter bit          APPEND_TERM = 1'b1,
  parameter logic [7:0]  TERM_CHAR   = ASCII_LF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done,
  input  logic [DIGEST_BITS-1:0] result,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned NIBBLES = DIGEST_BITS / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  ser_state_e             state;
  ser_state_e             next_state;
  logic                   done_d;
  logic                   start;
  logic                   fire;
  logic                   load;
  logic                   shift;
  logic [DIGEST_BITS-1:0] shreg;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             hex_char;

  assign start = done & ~done_d;
  assign fire  = out_valid & out_ready;

  sha256_nibble_to_ascii u_n2a (
    .nibble (shreg[DIGEST_BITS-1 -: 4]),
    .ascii  (hex_char)
  );

  // State register, done edge detector and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      done_d  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= next_state;
      done_d <= done;
      if (start && busy) begin
        overrun <= 1'b1;
      end
    end
  end

  // Digest shift register and remaining-nibble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register is cleared on reset so a fresh frame never exposes stale digest bits.
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= result;
      cnt   <= CNT_W'(NIBBLES - 1);
    end else if (shift) begin
      shreg <= {shreg[DIGEST_BITS-5:0], 4'h0};
      cnt   <= cnt - CNT_W'(1);
    end
  end

  // Next-state logic and stream outputs; a start outside IDLE is ignored.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    busy       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = ST_HEX;
        end
      end
      ST_HEX: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = hex_char;
        if (fire) begin
          shift = 1'b1;
          if (cnt == '0) begin
            next_state = APPEND_TERM ? ST_TERM : ST_IDLE;
          end
        end
      end
      ST_TERM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = TERM_CHAR;
        if (fire) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_hex_serializer.sv
// Scoreboard bench for sha256_hex_serializer: one instance with terminator,
// one without. Expected bytes come from the %h text of each digest.
// Honours SHA256_HEX_UPPERCASE_EN when building expected characters.
module tb_sha256_hex_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done = 1'b0;
  logic         done_nt = 1'b0;
  logic [255:0] result = '0;
  logic         out_ready = 1'b1;
  logic         out_valid, out_valid_nt;
  logic [7:0]   out_data, out_data_nt;
  logic         busy, busy_nt;
  logic         overrun, overrun_nt;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q_nt[$];

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  sha256_hex_serializer dut (
    .clk(clk), .rst(rst), .done(done), .result(result), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .overrun(overrun)
  );

  sha256_hex_serializer #(.APPEND_TERM(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .done(done_nt), .result(result), .out_ready(out_ready),
    .out_valid(out_valid_nt), .out_data(out_data_nt), .busy(busy_nt), .overrun(overrun_nt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sel_valid(input bit which);
    return which ? out_valid_nt : out_valid;
  endfunction

  function automatic logic sel_busy(input bit which);
    return which ? busy_nt : busy;
  endfunction

  // Reference: the digest printed as hex text, one character per byte.
  function automatic void push_frame(input bit which, input logic [255:0] d);
    string s;
    s = $sformatf("%h", d);
`ifdef SHA256_HEX_UPPERCASE_EN
    s = s.toupper();
`endif
    for (int i = 0; i < s.len(); i++) begin
      if (which) exp_q_nt.push_back(s[i]);
      else       exp_q.push_back(s[i]);
    end
    if (!which) exp_q.push_back(8'h0A);
  endfunction

  // Monitor for the terminated instance: pops on every handshake, checks stall stability.
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", {23'h0, out_valid, out_data}, {23'h0, 1'b1, stall_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
        else check("byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // Monitor for the unterminated instance.
  always @(negedge clk) begin
    if (!rst && out_valid_nt && out_ready) begin
      if (exp_q_nt.size() == 0) check("nt_unexpected_byte", {24'h0, out_data_nt}, 32'hFFFF_FFFF);
      else check("nt_byte", {24'h0, out_data_nt}, {24'h0, exp_q_nt.pop_front()});
    end
  end

  // Raise done with a digest; verifies the one-cycle latency. Ends at a negedge with out_valid high.
  task automatic issue(input bit which, input logic [255:0] d, input bit hold);
    @(posedge clk); #1;
    result = d;
    if (which) done_nt = 1'b1;
    else       done    = 1'b1;
    push_frame(which, d);
    @(negedge clk);
    check("pre_latency_valid", {31'h0, sel_valid(which)}, 32'd0);
    @(posedge clk); #1;
    if (!hold) begin
      done    = 1'b0;
      done_nt = 1'b0;
    end
    @(negedge clk);
    check("latency_valid", {31'h0, sel_valid(which)}, 32'd1);
    check("latency_busy", {31'h0, sel_busy(which)}, 32'd1);
  endtask

  // Drive out_ready until busy drops; mode 0 = always 1, 1 = toggle, 2 = random.
  // poke_at >= 0 pulses done (with a new random result) mid-frame.
  task automatic run_frame(input bit which, input int mode, input int exp_cycles, input int poke_at);
    int n = 0;
    while (sel_busy(which) && n < 2000) begin
      @(posedge clk); #1;
      case (mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (poke_at >= 0) begin
        if (n == poke_at) begin
          done   = 1'b1;
          result = {8{$urandom()}};
        end else if (n == poke_at + 1) begin
          done = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("frame_timeout", 32'(n), 32'd0);
    else if (exp_cycles > 0) check("frame_cycles", 32'(n), 32'(exp_cycles));
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    exp_q_nt.delete();
    #1;
    check("async_rst_valid", {31'h0, out_valid}, 32'd0);
    check("async_rst_busy", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] pat;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data", {24'h0, out_data}, 32'h00);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_overrun", {31'h0, overrun}, 32'd0);
    rst = 1'b0;

    // "abc" digest with out_ready high: 65 consecutive bytes.
    issue(1'b0, ABC_DIGEST, 1'b0);
    run_frame(1'b0, 0, 65, -1);
    check("abc_busy_after", {31'h0, busy}, 32'd0);

    // All-zero digest with out_ready toggling: 129 cycles.
    issue(1'b0, '0, 1'b0);
    run_frame(1'b0, 1, 129, -1);

    // Random digests with random back-pressure.
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, {8{$urandom()}}, 1'b0);
      run_frame(1'b0, 2, -1, -1);
    end

    // done held high for ~200 cycles: one frame only, no overrun.
    issue(1'b0, {8{$urandom()}}, 1'b1);
    run_frame(1'b0, 0, 65, -1);
    repeat (133) @(posedge clk);
    #1 done = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_overrun", {31'h0, overrun}, 32'd0);
    check("hold_busy", {31'h0, busy}, 32'd0);

    // Second done rise at byte 10: frame unchanged, overrun sticky, no second frame.
    issue(1'b0, {8{$urandom()}}, 1'b0);
    run_frame(1'b0, 0, 65, 9);
    check("overrun_set", {31'h0, overrun}, 32'd1);
    repeat (20) @(negedge clk);
    check("overrun_sticky", {31'h0, overrun}, 32'd1);
    check("overrun_no_frame", {31'h0, busy}, 32'd0);

    // Reset at byte 30, done already high at release: fresh FF..FF frame.
    issue(1'b0, {8{$urandom()}}, 1'b0);
    repeat (30) @(posedge clk);
    do_reset();
    check("rst_clears_overrun", {31'h0, overrun}, 32'd0);
    result = '1;
    done   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_frame(1'b0, '1);
    @(negedge clk);
    check("post_rst_pre_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'h0, out_valid}, 32'd1);
    run_frame(1'b0, 0, 65, -1);

    // done rise coinciding with the final handshake counts as busy.
    issue(1'b0, {8{$urandom()}}, 1'b0);
    run_frame(1'b0, 0, 65, 63);
    check("final_hs_overrun", {31'h0, overrun}, 32'd1);
    repeat (10) @(negedge clk);
    check("final_hs_no_frame", {31'h0, busy}, 32'd0);

    // No terminator: 64 bytes, busy falls on the 64th handshake.
    pat = {4{64'h0123456789abcdef}};
    issue(1'b1, pat, 1'b0);
    run_frame(1'b1, 0, 64, -1);
    repeat (5) @(negedge clk);
    check("nt_busy_after", {31'h0, busy_nt}, 32'd0);
    check("nt_overrun", {31'h0, overrun_nt}, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("nt_queue_drained", 32'(exp_q_nt.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_hex_serializer.md
Name: sha256_hex_serializer

Overview:
Consumes the 256-bit digest presented by the SHA256 core on its done/result interface. Emits it as a stream of 64 ASCII hex characters, optionally followed by a terminator byte, on an 8-bit valid/ready byte interface. This is the byte-stream egress opposite the core's byte-stream ingress (in/data_valid). It lets the digest be shipped over a UART or byte bus without a host formatting it.

Parameters:
DIGEST_BITS, 256, digest width; must be a multiple of 4; NIBBLES = DIGEST_BITS/4.
APPEND_TERM, 1, 1 = send TERM_CHAR after the last hex char; 0 = no terminator.
TERM_CHAR, 8'h0A, terminator byte value.

Ports:
clk  input  1  single clock; all state on posedge.
rst  input  1  asynchronous, active-high reset.
done  input  1  core done level; a rising edge requests serialization.
result  input  DIGEST_BITS  core digest; sampled on the cycle done rises.
out_ready  input  1  downstream accepts a byte when high with out_valid.
out_valid  output  1  out_data holds a valid byte.
out_data  output  8  ASCII byte.
busy  output  1  high from capture until the final byte is accepted.
overrun  output  1  sticky; set when a done rise occurs while busy.

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid=0, out_data=8'h00, busy=0, overrun=0; shift register, nibble counter and done_d cleared.
- Edge detect: done_d registers done; start = done & ~done_d. A done held high triggers exactly once.
- FSM states:
  - IDLE: on start, load result into the shift register, counter=NIBBLES-1, go to HEX. busy=1 and out_valid=1 on the next cycle, with out_data = hex of result[DIGEST_BITS-1 -: 4]. Latency from done rise to first out_valid is 1 cycle.
  - HEX: on a handshake (out_valid & out_ready), shift left 4 and decrement the counter.
    - Handshake with counter==0 goes to TERM if APPEND_TERM, otherwise to IDLE.
    - Without a handshake, out_valid and out_data stay stable.
  - TERM: out_data=TERM_CHAR, out_valid=1; on handshake go to IDLE.
  - On entry to IDLE: out_valid=0, busy=0.
- Back-to-back throughput is 1 byte/cycle with out_ready held high. A full frame takes NIBBLES (+1) handshakes.
- Hex map: n<10 gives 8'h30+n; n>=10 gives 8'h61+(n-10) (lowercase).
- Nibble order is MSB first, matching %h formatting of result.
- A start while busy is ignored and the frame in progress is unaffected. overrun is set and stays set until rst.
- A start in the same cycle as the final handshake counts as busy: it is ignored and sets overrun.
- out_ready while out_valid=0 is ignored.
- rst mid-frame aborts immediately with no partial terminator. The next done rise after reset starts a fresh frame. If done is already high when rst releases, done_d=0 makes it a rising edge and a frame starts.

Optional Feature:
Macro SHA256_HEX_UPPERCASE_EN.
- Defined: hex digits a-f map to 8'h41+(n-10) ('A'-'F').
- Undefined: lowercase 8'h61+(n-10).
- Digits 0-9 are unaffected either way.

Decomposition:
- Shared package sha256_pkg:
  - DIGEST_BITS default constant.
  - ASCII constants (ASCII_0=8'h30, ASCII_LA=8'h61, ASCII_UA=8'h41, ASCII_LF=8'h0A).
  - FSM state encoding (IDLE, HEX, TERM).
- One sub-module: sha256_nibble_to_ascii, purely combinational 4-bit to 8-bit, honouring SHA256_HEX_UPPERCASE_EN.

Test Plan:
- "abc" digest ba7816bf...f20015ad with done rise and out_ready=1: the 65 bytes are 0x62,0x61,0x37,...,0x61,0x64,0x0A on consecutive cycles; first out_valid 1 cycle after the done rise; busy drops after the 0x0A handshake.
- All-zero digest with out_ready toggling 1/0 each cycle: 64×0x30 then 0x0A, with out_data stable during every stall; total 129 cycles after the first valid.
- done held high for 200 cycles: exactly one frame, and overrun stays 0.
- Second done rise at byte 10 of a frame: the frame completes unchanged, overrun=1 and stays 1, and no second frame is emitted.
- rst asserted at byte 30: out_valid=0 and busy=0 immediately (asynchronous). Next done rise with digest FF..FF gives 64×0x66 (0x46 with SHA256_HEX_UPPERCASE_EN) then 0x0A.
- APPEND_TERM=0 with digest 0123...ef repeated: 64 bytes, last byte 0x66, no 0x0A; busy falls on the 64th handshake.
